// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM encoding, access sizes, owner ids.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [1:0] SZ_WORD = 2'b11;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b00;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait-state counter; expired_o flags the last cycle allowed before abort.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // Counter holds the number of BUSY cycles already elapsed, so the TIMEOUT-th
  // cycle is the one where it reads TIMEOUT-1.
  localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory bus between fetch (word reads) and MEM (loads/stores), data first.
// Each access: grant, BUSY until mAck or timeout, one DONE cycle that pulses the owner's valid.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  input  logic        iFlush,
  output logic [31:0] iRdata,
  output logic        iValid,
  output logic        iStall,
  input  logic        dReq,
  input  logic        dWr,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [1:0]  dSize,
  output logic [31:0] dRdata,
  output logic        dValid,
  output logic        dStall,
  output logic        mReq,
  output logic        mWr,
  output logic [31:0] mAddr,
  output logic [31:0] mWdata,
  output logic [1:0]  mSize,
  input  logic        mAck,
  input  logic [31:0] mRdata,
  output logic        busErr
);

  state_e      state_q;
  logic        owner_q;
  logic        squash_q;
  logic        mreq_q;
  logic        mwr_q;
  logic [31:0] maddr_q;
  logic [31:0] mwdata_q;
  logic [1:0]  msize_q;
  logic [31:0] irdata_q;
  logic [31:0] drdata_q;
  logic        ivalid_q;
  logic        dvalid_q;
  logic        buserr_q;
  logic        busy;
  logic        expired;

  assign busy = (state_q == BUSY_D) || (state_q == BUSY_I);

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (~busy),
    .en_i     (busy),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_D;
      squash_q <= 1'b0;
      mreq_q   <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      msize_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dReq) begin
            state_q  <= BUSY_D;
            owner_q  <= OWN_D;
            mreq_q   <= 1'b1;
            mwr_q    <= dWr;
            maddr_q  <= dAddr;
            mwdata_q <= dWdata;
            msize_q  <= dSize;
          end else if (iReq && !iFlush) begin
            state_q  <= BUSY_I;
            owner_q  <= OWN_I;
            mreq_q   <= 1'b1;
            mwr_q    <= 1'b0;
            maddr_q  <= iAddr;
            mwdata_q <= '0;
            msize_q  <= SZ_WORD;
          end
        end
        BUSY_D, BUSY_I: begin
          if ((state_q == BUSY_I) && iFlush) begin
            squash_q <= 1'b1;
          end
          // An ack arriving on the timeout cycle still completes normally.
          if (mAck || expired) begin
            state_q <= DONE;
            mreq_q  <= 1'b0;
            if (!mAck) begin
              buserr_q <= 1'b1;
            end
            if (owner_q == OWN_I) begin
              irdata_q <= mAck ? mRdata : '0;
              ivalid_q <= !(squash_q || iFlush);
            end else begin
              if (!mAck) begin
                drdata_q <= '0;
              end else if (!mwr_q) begin
                drdata_q <= mRdata;
              end
              dvalid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q  <= IDLE;
          squash_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mReq   = mreq_q;
  assign mWr    = mwr_q;
  assign mAddr  = maddr_q;
  assign mWdata = mwdata_q;
  assign mSize  = msize_q;
  assign iRdata = irdata_q;
  assign dRdata = drdata_q;
  assign iValid = ivalid_q;
  assign dValid = dvalid_q;
  assign busErr = buserr_q;

  assign dStall = dReq & ~dvalid_q;
  assign iStall = iReq & ~ivalid_q & ~iFlush;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: bus issues and completions are checked against queued expectations.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } bus_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iReq, iFlush, iValid, iStall;
  logic [31:0] iAddr, iRdata;
  logic        dReq, dWr, dValid, dStall;
  logic [31:0] dAddr, dWdata, dRdata;
  logic [1:0]  dSize;
  logic        mReq, mWr, mAck, busErr;
  logic [31:0] mAddr, mWdata, mRdata;
  logic [1:0]  mSize;

  int   checks = 0;
  int   failures = 0;
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   ack_wait = -1;
  bit   force_ack = 1'b0;
  bit   mreq_prev = 1'b0;
  int   bcnt = 0;
  int   mreq_cycles = 0;
  int   n;
  logic [31:0] exp_drdata;

  mem_port_arbiter #(.TIMEOUT(4), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iAddr(iAddr), .iFlush(iFlush), .iRdata(iRdata), .iValid(iValid), .iStall(iStall),
    .dReq(dReq), .dWr(dWr), .dAddr(dAddr), .dWdata(dWdata), .dSize(dSize),
    .dRdata(dRdata), .dValid(dValid), .dStall(dStall),
    .mReq(mReq), .mWr(mWr), .mAddr(mAddr), .mWdata(mWdata), .mSize(mSize),
    .mAck(mAck), .mRdata(mRdata), .busErr(busErr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock, score registered outputs, then drive this cycle's memory response.
  task automatic step();
    bus_t b;
    rsp_t r;
    @(posedge clk);
    #1;
    if (mReq) begin
      mreq_cycles++;
      bcnt = mreq_prev ? bcnt + 1 : 0;
    end
    if (mReq && !mreq_prev) begin
      chk("bus_pending", 32'(bus_q.size() != 0), 1);
      if (bus_q.size() != 0) begin
        b = bus_q.pop_front();
        chk("bus_wr", 32'(mWr), 32'(b.wr));
        chk("bus_addr", mAddr, b.addr);
        chk("bus_size", 32'(mSize), 32'(b.size));
        if (b.wr) chk("bus_wdata", mWdata, b.wdata);
      end
    end
    mreq_prev = mReq;
    if (dValid || iValid) begin
      chk("rsp_pending", 32'(rsp_q.size() != 0), 1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        chk("rsp_owner_d", 32'(dValid), 32'(r.is_d));
        chk("rsp_owner_i", 32'(iValid), 32'(!r.is_d));
        chk("rsp_rdata", r.is_d ? dRdata : iRdata, r.rdata);
      end
    end
    mAck   = force_ack || (mReq && (ack_wait >= 0) && (bcnt == ack_wait));
    mRdata = mAck ? mem_fn(mAddr) : 32'hFFFF_FFFF;
  endtask

  task automatic wait_valid(input bit is_d, input int budget, output int cyc);
    cyc = 0;
    while (!(is_d ? dValid : iValid) && cyc < budget) begin
      step();
      cyc++;
    end
    chk(is_d ? "wait_dvalid" : "wait_ivalid", 32'(is_d ? dValid : iValid), 1);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_mReq"}, 32'(mReq), 0);
    chk({pfx, "_mWr"}, 32'(mWr), 0);
    chk({pfx, "_mAddr"}, mAddr, 0);
    chk({pfx, "_mWdata"}, mWdata, 0);
    chk({pfx, "_mSize"}, 32'(mSize), 0);
    chk({pfx, "_iRdata"}, iRdata, 0);
    chk({pfx, "_dRdata"}, dRdata, 0);
    chk({pfx, "_iValid"}, 32'(iValid), 0);
    chk({pfx, "_dValid"}, 32'(dValid), 0);
    chk({pfx, "_busErr"}, 32'(busErr), 0);
  endtask

  task automatic push_d(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic [31:0] rd, input bit want_rsp);
    dReq = 1'b1; dWr = wr; dAddr = a; dWdata = wd; dSize = sz;
    bus_q.push_back('{wr: wr, addr: a, wdata: wd, size: sz});
    if (want_rsp) rsp_q.push_back('{is_d: 1'b1, rdata: rd});
  endtask

  task automatic push_i(input logic [31:0] a, input bit want_rsp);
    iReq = 1'b1; iAddr = a;
    bus_q.push_back('{wr: 1'b0, addr: a, wdata: 32'h0, size: SZ_WORD});
    if (want_rsp) rsp_q.push_back('{is_d: 1'b0, rdata: mem_fn(a)});
  endtask

  initial begin
    rst = 1'b1; iReq = 0; iAddr = 0; iFlush = 0; dReq = 0; dWr = 0; dAddr = 0;
    dWdata = 0; dSize = 0; mAck = 0; mRdata = 0;
    repeat (3) step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // Single-cycle word load.
    ack_wait = 0; mreq_cycles = 0;
    push_d(1'b0, 32'h100, 32'h0, SZ_WORD, 32'hDEADBEEF, 1'b1);
    #1 chk("t1_c0_dstall", 32'(dStall), 1);
    chk("t1_c0_mreq", 32'(mReq), 0);
    step(); chk("t1_c1_mreq", 32'(mReq), 1);
    #1 chk("t1_c1_dstall", 32'(dStall), 1);
    step(); chk("t1_c2_dvalid", 32'(dValid), 1);
    chk("t1_c2_drdata", dRdata, 32'hDEADBEEF);
    #1 chk("t1_c2_dstall", 32'(dStall), 0);
    dReq = 0;
    step(); chk("t1_c3_dvalid", 32'(dValid), 0);
    chk("t1_mreq_cycles", mreq_cycles, 1);
    exp_drdata = 32'hDEADBEEF;

    // Simultaneous requests: data first, fetch after the DONE bubble.
    push_d(1'b0, 32'h200, 32'h0, SZ_WORD, mem_fn(32'h200), 1'b1);
    push_i(32'h4000, 1'b1);
    step(); chk("t2_c1_maddr", mAddr, 32'h200);
    step(); chk("t2_c2_dvalid", 32'(dValid), 1);
    dReq = 0;
    #1 chk("t2_c2_istall", 32'(iStall), 1);
    step(); chk("t2_c3_mreq", 32'(mReq), 0);
    step(); chk("t2_c4_mreq", 32'(mReq), 1);
    chk("t2_c4_maddr", mAddr, 32'h4000);
    chk("t2_c4_msize", 32'(mSize), 32'(SZ_WORD));
    chk("t2_c4_mwr", 32'(mWr), 0);
    step(); chk("t2_c5_ivalid", 32'(iValid), 1);
    iReq = 0;
    step();
    exp_drdata = mem_fn(32'h200);

    // Byte store with three wait states; dRdata must not change.
    ack_wait = 3; mreq_cycles = 0;
    push_d(1'b1, 32'h300, 32'h0000_00AB, SZ_BYTE, exp_drdata, 1'b1);
    wait_valid(1'b1, 20, n);
    chk("t3_valid_latency", n, 5);
    chk("t3_mreq_cycles", mreq_cycles, 4);
    dReq = 0;
    step();

    // Flush during BUSY_I: transaction completes but no iValid.
    ack_wait = 2;
    push_i(32'h5000, 1'b0);
    step(); chk("t4_c1_mreq", 32'(mReq), 1);
    iFlush = 1; iReq = 0;
    #1 chk("t4_c1_istall", 32'(iStall), 0);
    step(); iFlush = 0;
    #1 chk("t4_c2_istall", 32'(iStall), 0);
    chk("t4_c2_mreq", 32'(mReq), 1);
    step();
    step(); chk("t4_c4_ivalid", 32'(iValid), 0);
    step(); chk("t4_c5_ivalid", 32'(iValid), 0);
    chk("t4_c5_mreq", 32'(mReq), 0);

    // Flush in IDLE blocks the grant for that cycle only.
    iReq = 1; iAddr = 32'h6000; iFlush = 1;
    #1 chk("t4b_c0_istall", 32'(iStall), 0);
    step(); chk("t4b_c1_mreq", 32'(mReq), 0);
    iFlush = 0; ack_wait = 0;
    push_i(32'h6000, 1'b1);
    #1 chk("t4b_c1_istall", 32'(iStall), 1);
    wait_valid(1'b0, 20, n);
    chk("t4b_valid_latency", n, 2);
    iReq = 0;
    step();

    // Timeout: 4 BUSY cycles, busErr sticky, dRdata zeroed, late ack ignored.
    ack_wait = -1; mreq_cycles = 0;
    push_d(1'b0, 32'h600, 32'h0, SZ_WORD, 32'h0, 1'b1);
    wait_valid(1'b1, 20, n);
    chk("t5_valid_latency", n, 5);
    chk("t5_mreq_cycles", mreq_cycles, 4);
    chk("t5_buserr", 32'(busErr), 1);
    dReq = 0;
    step();
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    step(); chk("t5_late_dvalid", 32'(dValid), 0);
    chk("t5_late_drdata", dRdata, 32'h0);
    chk("t5_late_mreq", 32'(mReq), 0);
    repeat (3) step();
    chk("t5_buserr_sticky", 32'(busErr), 1);

    // Reset in the second BUSY cycle, then re-issue the held request.
    push_d(1'b0, 32'h700, 32'h0, SZ_WORD, 32'h0, 1'b0);
    step(); chk("t6_c1_mreq", 32'(mReq), 1);
    step(); rst = 1'b1;
    step(); chk_zero("t6_rst");
    rst = 1'b0; ack_wait = 1;
    push_d(1'b0, 32'h700, 32'h0, SZ_WORD, mem_fn(32'h700), 1'b1);
    wait_valid(1'b1, 20, n);
    chk("t6_reissue_latency", n, 3);
    dReq = 0;
    repeat (2) step();

    chk("end_bus_q_empty", bus_q.size(), 0);
    chk("end_rsp_q_empty", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
